// File: rtl/core_fetch.sv
// Instruction fetch front end: issues one word read at a time, buffers returned
// words with their halfword PCs in a prefetch FIFO, and flushes on every redirect.
module core_fetch #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        branch,
   input  logic [30:0] target,
   input  logic        stall,
   output logic        mem_start,
   output logic [29:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_data,
   output logic [31:0] insn,
   output logic [30:0] insn_pc,
   output logic        insn_valid
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   typedef enum logic [1:0] {
      S_HALT    = 2'd0,
      S_FETCH   = 2'd1,
      S_WAIT    = 2'd2,
      S_DISCARD = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [30:0]   pc_q, pc_d, redirect_pc;
   logic [AW:0]   count_q;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [62:0]   fifo_mem [DEPTH];
   logic          push, pop;

   // Word fetch: the halfword bit of a redirect target is dropped on purpose.
   logic unused_target_lsb;
   assign unused_target_lsb = target[0];

   // Handshakes: mem_start is a one-cycle request, answered by at most one
   // mem_ready no earlier than the next cycle; decode takes the FIFO head in
   // every cycle where insn_valid is high and stall is low.
   assign redirect_pc = {target[30:1], 1'b0};
   assign mem_addr    = pc_q[30:1];
   assign insn_valid  = (count_q != '0) && !branch;
   assign pop         = insn_valid && !stall;
   assign {insn, insn_pc} = fifo_mem[rd_ptr_q];

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      mem_start = 1'b0;
      push      = 1'b0;
      case (state_q)
         S_HALT: begin
            if (branch) begin
               pc_d    = redirect_pc;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (branch) begin
               pc_d = redirect_pc;
            end else if (count_q < FULL) begin
               mem_start = 1'b1;
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            // A redirect racing the reply drops the word; otherwise the read is still owed.
            if (branch) begin
               pc_d    = redirect_pc;
               state_d = mem_ready ? S_FETCH : S_DISCARD;
            end else if (mem_ready) begin
               push    = 1'b1;
               pc_d    = pc_q + 31'd2;
               state_d = S_FETCH;
            end
         end
         S_DISCARD: begin
            if (branch) pc_d = redirect_pc;
            if (mem_ready) state_d = S_FETCH;
         end
         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_HALT;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (branch) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (push && !pop)      count_q <= count_q + CNT_ONE;
         else if (!push && pop) count_q <= count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= {mem_data, pc_q};
   end

endmodule

// File: tb/tb_core_fetch.sv
// Bench for core_fetch: a latency-configurable memory responder plus a reference
// model of the expected in-order instruction stream starting at each redirect.
module tb_core_fetch;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        branch = 1'b0;
   logic [30:0] target = '0;
   logic        stall = 1'b0;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_data = '0;
   logic        mem_start;
   logic [29:0] mem_addr;
   logic [31:0] insn;
   logic [30:0] insn_pc;
   logic        insn_valid;

   int n_checks = 0;
   int n_fail   = 0;
   int mem_lat  = 1;

   logic [31:0] mem_img [logic [29:0]];
   logic [30:0] exp_q [$];

   core_fetch #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .branch(branch), .target(target), .stall(stall),
      .mem_start(mem_start), .mem_addr(mem_addr), .mem_ready(mem_ready),
      .mem_data(mem_data), .insn(insn), .insn_pc(insn_pc), .insn_valid(insn_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] word_of(input logic [29:0] a);
      if (!mem_img.exists(a)) mem_img[a] = $urandom;
      return mem_img[a];
   endfunction

   // Memory: answers each request mem_lat cycles later with the image word.
   initial begin : responder
      logic        st;
      logic [29:0] a;
      logic [29:0] rsp_addr;
      int          timer;
      timer = 0;
      rsp_addr = '0;
      forever begin
         @(negedge clk);
         st = mem_start;
         a  = mem_addr;
         @(posedge clk);
         #1;
         mem_ready = 1'b0;
         mem_data  = $urandom;
         if (st) begin
            rsp_addr = a;
            timer    = mem_lat;
         end
         if (timer > 0) begin
            timer--;
            if (timer == 0) begin
               mem_ready = 1'b1;
               mem_data  = word_of(rsp_addr);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      branch = 1'b0;
      stall  = 1'b0;
      repeat (4) tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      mem_lat = 1;
      do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_start !== 1'b0 || insn_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: mem_start=%b insn_valid=%b expected 0 0", mem_start, insn_valid);
      end
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_checks++;
         if (mem_start !== 1'b0 || insn_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_halt: cycle %0d mem_start=%b insn_valid=%b expected 0 0", c, mem_start, insn_valid);
         end
         tick();
      end
      branch = 1'b1;
      target = 31'h0;
      @(negedge clk);
      n_checks++;
      if (mem_start !== 1'b0) begin
         n_fail++;
         $display("FAIL first_redirect_quiet: mem_start=%b expected 0", mem_start);
      end
      tick();
      branch = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_start !== 1'b1 || mem_addr !== 30'h0) begin
         n_fail++;
         $display("FAIL first_fetch: mem_start=%b mem_addr=%h expected 1 0", mem_start, mem_addr);
      end
   endtask

   task automatic test_stream();
      logic [30:0] exp_pc;
      int acc;
      mem_lat = 1;
      do_reset();
      branch = 1'b1;
      target = 31'h40;
      @(negedge clk);
      n_checks++;
      if (mem_start !== 1'b0 || insn_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL redir_c0: mem_start=%b insn_valid=%b expected 0 0", mem_start, insn_valid);
      end
      tick();
      branch = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_start !== 1'b1 || mem_addr !== 30'h20) begin
         n_fail++;
         $display("FAIL redir_c1: mem_start=%b mem_addr=%h expected 1 20", mem_start, mem_addr);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (insn_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL redir_c2: insn_valid=%b expected 0 (no bypass)", insn_valid);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (insn_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL redir_c3: insn_valid=%b expected 1", insn_valid);
      end
      exp_pc = 31'h40;
      acc = 0;
      for (int c = 0; c < 16; c++) begin
         if (c > 0) begin
            tick();
            @(negedge clk);
         end
         if (insn_valid && !stall) begin
            n_checks++;
            if (insn_pc !== exp_pc || insn !== word_of(exp_pc[30:1])) begin
               n_fail++;
               $display("FAIL stream_word: pc=%h insn=%h expected pc=%h insn=%h", insn_pc, insn, exp_pc, word_of(exp_pc[30:1]));
            end
            exp_pc = exp_pc + 31'd2;
            acc++;
         end
      end
      n_checks++;
      if (acc != 8) begin
         n_fail++;
         $display("FAIL stream_rate: %0d words in 16 cycles expected 8", acc);
      end
   endtask

   task automatic test_stall();
      logic [30:0] exp_pc;
      int starts, acc;
      bit seen;
      mem_lat = 1;
      do_reset();
      stall  = 1'b1;
      branch = 1'b1;
      target = 31'h40;
      @(negedge clk);
      tick();
      branch = 1'b0;
      starts = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (mem_start) starts++;
         tick();
      end
      n_checks++;
      if (starts != DEPTH) begin
         n_fail++;
         $display("FAIL stall_fill: %0d requests while stalled expected %0d", starts, DEPTH);
      end
      stall = 1'b0;
      exp_pc = 31'h40;
      acc = 0;
      seen = 1'b0;
      for (int c = 0; c < 40 && acc < 8; c++) begin
         @(negedge clk);
         if (mem_start && !seen) begin
            seen = 1'b1;
            n_checks++;
            if (mem_addr !== 30'h24) begin
               n_fail++;
               $display("FAIL stall_resume_addr: mem_addr=%h expected 24", mem_addr);
            end
         end
         if (insn_valid && !stall) begin
            n_checks++;
            if (insn_pc !== exp_pc || insn !== word_of(exp_pc[30:1])) begin
               n_fail++;
               $display("FAIL stall_drain_word: pc=%h insn=%h expected pc=%h insn=%h", insn_pc, insn, exp_pc, word_of(exp_pc[30:1]));
            end
            exp_pc = exp_pc + 31'd2;
            acc++;
         end
         tick();
      end
      n_checks++;
      if (acc != 8 || !seen) begin
         n_fail++;
         $display("FAIL stall_drain: words=%0d resumed=%0d expected 8 1", acc, seen);
      end
   endtask

   task automatic test_wrong_path();
      logic [30:0] exp_pc;
      int acc;
      mem_lat = 3;
      do_reset();
      branch = 1'b1;
      target = 31'h40;
      @(negedge clk);
      tick();
      branch = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_start !== 1'b1 || mem_addr !== 30'h20) begin
         n_fail++;
         $display("FAIL wp_first_req: mem_start=%b mem_addr=%h expected 1 20", mem_start, mem_addr);
      end
      tick();
      branch = 1'b1;
      target = 31'h100;
      @(negedge clk);
      tick();
      branch = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++;
         if (mem_start !== 1'b0 || insn_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wp_discard: cycle %0d mem_start=%b insn_valid=%b expected 0 0", c, mem_start, insn_valid);
         end
         tick();
      end
      @(negedge clk);
      n_checks++;
      if (mem_start !== 1'b1 || mem_addr !== 30'h80) begin
         n_fail++;
         $display("FAIL wp_new_req: mem_start=%b mem_addr=%h expected 1 80", mem_start, mem_addr);
      end
      exp_pc = 31'h100;
      acc = 0;
      for (int c = 0; c < 40 && acc < 3; c++) begin
         tick();
         @(negedge clk);
         if (insn_valid && !stall) begin
            n_checks++;
            if (insn_pc !== exp_pc || insn !== word_of(exp_pc[30:1])) begin
               n_fail++;
               $display("FAIL wp_word: pc=%h insn=%h expected pc=%h insn=%h", insn_pc, insn, exp_pc, word_of(exp_pc[30:1]));
            end
            exp_pc = exp_pc + 31'd2;
            acc++;
         end
      end
      n_checks++;
      if (acc != 3) begin
         n_fail++;
         $display("FAIL wp_timeout: %0d words expected 3", acc);
      end
   endtask

   task automatic test_flush_coincident();
      logic [30:0] exp_pc;
      int starts, acc;
      mem_lat = 1;
      do_reset();
      stall  = 1'b1;
      branch = 1'b1;
      target = 31'h40;
      @(negedge clk);
      tick();
      branch = 1'b0;
      starts = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mem_start) starts++;
         tick();
         if (starts == 3) break;
      end
      n_checks++;
      if (starts != 3) begin
         n_fail++;
         $display("FAIL flush_setup: %0d requests seen expected 3", starts);
      end
      branch = 1'b1;
      target = 31'h200;
      stall  = 1'b0;
      @(negedge clk);
      n_checks++;
      if (insn_valid !== 1'b0 || mem_start !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_cycle: insn_valid=%b mem_start=%b expected 0 0", insn_valid, mem_start);
      end
      tick();
      branch = 1'b0;
      @(negedge clk);
      n_checks++;
      if (insn_valid !== 1'b0 || mem_start !== 1'b1 || mem_addr !== 30'h100) begin
         n_fail++;
         $display("FAIL flush_after: insn_valid=%b mem_start=%b mem_addr=%h expected 0 1 100", insn_valid, mem_start, mem_addr);
      end
      exp_pc = 31'h200;
      acc = 0;
      for (int c = 0; c < 30 && acc < 2; c++) begin
         tick();
         @(negedge clk);
         if (insn_valid && !stall) begin
            n_checks++;
            if (insn_pc !== exp_pc || insn !== word_of(exp_pc[30:1])) begin
               n_fail++;
               $display("FAIL flush_word: pc=%h insn=%h expected pc=%h insn=%h", insn_pc, insn, exp_pc, word_of(exp_pc[30:1]));
            end
            exp_pc = exp_pc + 31'd2;
            acc++;
         end
      end
      n_checks++;
      if (acc != 2) begin
         n_fail++;
         $display("FAIL flush_timeout: %0d words expected 2", acc);
      end
   endtask

   task automatic test_wrap();
      logic [30:0] exp_pc;
      mem_lat = $urandom_range(1, 3);
      do_reset();
      exp_q.delete();
      exp_q.push_back(31'h7FFFFFFC);
      exp_q.push_back(31'h7FFFFFFE);
      exp_q.push_back(31'h0);
      exp_q.push_back(31'h2);
      branch = 1'b1;
      target = 31'h7FFFFFFC;
      @(negedge clk);
      tick();
      branch = 1'b0;
      for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
         @(negedge clk);
         if (insn_valid && !stall) begin
            exp_pc = exp_q.pop_front();
            n_checks++;
            if (insn_pc !== exp_pc || insn !== word_of(exp_pc[30:1])) begin
               n_fail++;
               $display("FAIL wrap_word: pc=%h insn=%h expected pc=%h insn=%h", insn_pc, insn, exp_pc, word_of(exp_pc[30:1]));
            end
         end
         tick();
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL wrap_timeout: %0d words missing expected 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      mem_lat = 3;
      do_reset();
      branch = 1'b1;
      target = 31'h40;
      @(negedge clk);
      tick();
      branch = 1'b0;
      @(negedge clk);
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_checks++;
         if (mem_start !== 1'b0 || insn_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_halt: cycle %0d mem_start=%b insn_valid=%b expected 0 0", c, mem_start, insn_valid);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [30:0] exp_pc;
      int acc;
      do_reset();
      exp_pc = '0;
      acc = 0;
      for (int c = 0; c < 600; c++) begin
         mem_lat = $urandom_range(1, 3);
         stall   = ($urandom_range(0, 3) == 0);
         branch  = (c == 0) || ($urandom_range(0, 19) == 0);
         target  = 31'($urandom);
         @(negedge clk);
         if (branch) begin
            n_checks++;
            if (insn_valid !== 1'b0 || mem_start !== 1'b0) begin
               n_fail++;
               $display("FAIL rnd_branch_quiet: insn_valid=%b mem_start=%b expected 0 0", insn_valid, mem_start);
            end
            exp_pc = {target[30:1], 1'b0};
         end else if (insn_valid && !stall) begin
            n_checks++;
            if (insn_pc !== exp_pc || insn !== word_of(exp_pc[30:1])) begin
               n_fail++;
               $display("FAIL rnd_word: pc=%h insn=%h expected pc=%h insn=%h", insn_pc, insn, exp_pc, word_of(exp_pc[30:1]));
            end
            exp_pc = exp_pc + 31'd2;
            acc++;
         end
         tick();
      end
      branch = 1'b0;
      stall  = 1'b0;
      n_checks++;
      if (acc < 40) begin
         n_fail++;
         $display("FAIL rnd_progress: %0d words delivered expected at least 40", acc);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_wrong_path();
      test_flush_coincident();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/core_fetch.md
# core_fetch

Instruction fetch front end: consumes the `branch`/`target` redirect produced by the branch unit and feeds 32-bit instructions with their PCs to decode. It issues one-at-a-time word reads on the instruction bus, buffers returned words in a small prefetch FIFO, flushes on every redirect and discards any in-flight wrong-path read. It sits between the instruction memory port and `core_decode`. After reset it stays halted until the first redirect, which is the reset vector.

## Interface
- `DEPTH`, 4, prefetch FIFO entries; power of two, ≥2.
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `branch`  in  1  redirect request; when high, `target` is the new fetch PC.
- `target`  in  31  redirect halfword pointer (`hptr`); bit 0 is ignored (word fetch).
- `stall`  in  1  decode cannot accept this cycle.
- `mem_start`  out  1  single-cycle read request.
- `mem_addr`  out  30  word address = `pc[30:1]`.
- `mem_ready`  in  1  read data valid; at most one per `mem_start`, no earlier than the cycle after.
- `mem_data`  in  32  read data, qualified by `mem_ready`.
- `insn`  out  32  FIFO head instruction.
- `insn_pc`  out  31  FIFO head `hptr`.
- `insn_valid`  out  1  head valid for decode.

## Operation
- State: `pc` (31 bits), FIFO storage of `{insn, insn_pc}`, `count` (0..DEPTH), FSM state.
- FSM states and transitions:
  - HALT: no requests. `branch` → FETCH, `pc <= {target[30:1],0}`.
  - FETCH: `mem_start = (count < DEPTH) && !branch`, `mem_addr = pc[30:1]`. If `branch`, load `pc` and stay in FETCH. If a request is issued, go to WAIT.
  - WAIT: on `mem_ready`, push `{mem_data, pc}`, `pc <= pc + 2`, go to FETCH.
    - `branch` without `mem_ready`: load `pc`, go to DISCARD.
    - `branch` with `mem_ready` in the same cycle: drop the data, load `pc`, go to FETCH.
  - DISCARD: on `mem_ready`, drop the data and go to FETCH. `branch` here reloads `pc` and the state does not change.
- Flush: `branch` empties the FIFO (`count <= 0`, pointers reset) at the edge ending that cycle. It overrides any push or pop in the same cycle.
- Output: `insn_valid = (count != 0) && !branch`.
- Pop: on `insn_valid && !stall`.
- `count` update when there is no `branch`: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Push never occurs when `count == DEPTH`. This holds by construction because a request is issued only with `count < DEPTH` and there is only one request outstanding.
- `pc` arithmetic is modulo 2^31; wrap from `7FFFFFFE` to `0` is legal and not flagged.
- FIFO data is not bypassed. A returned word becomes visible the cycle after `mem_ready`.

## Timing
- Reset values: state HALT, `count` 0, `pc` 0, `mem_start` 0, `insn_valid` 0. `mem_addr`, `insn` and `insn_pc` are don't-care while their qualifier is low. FIFO storage is not reset.
- Reset mid-transaction: the FSM returns to HALT. A stale `mem_ready` arriving in HALT is ignored.
- Redirect latency, measured from `branch` in cycle 0:
  - `mem_start` in cycle 1, if a credit is available.
  - `mem_ready` in cycle 2 at the earliest.
  - `insn_valid` in cycle 3 at the earliest.
- Steady-state throughput: one word per 2 cycles when `mem_ready` returns the cycle after `mem_start` (FETCH→WAIT→FETCH).
- `mem_start` and `insn_valid` are combinational in `branch`. They are low in any cycle with `branch` high.
- `stall` only holds the FIFO head. It never blocks issue while `count < DEPTH`.

## Test plan
- Reset then idle, no `branch` for 10 cycles → `mem_start` never asserted and `insn_valid` stays 0. Then `branch`, `target=0` → `mem_addr=0` next cycle.
- Redirect to `target=0x40`, memory replying with 1-cycle latency, `stall=0` → `insn_pc` sequence `0x40, 0x42, 0x44…`, with `insn` matching the memory words.
- `stall=1` held continuously → exactly DEPTH (4) words fetched, then `mem_start` stays low. Release `stall` → FIFO drains in order and fetch resumes at `0x40+8`.
- `branch` to `0x100` while in WAIT, with `mem_ready` 3 cycles later → that data is dropped. The next `mem_addr` is `0x80` (word address of `0x100`), and the first `insn_pc` is `0x100`.
- `branch` coincident with `mem_ready` and a pop, with FIFO holding 2 entries → FIFO empty next cycle, data dropped, `insn_valid=0`, and the next request targets the new PC.
- Redirect to `target=0x7FFFFFFC` → fetched `insn_pc` sequence is `0x7FFFFFFC, 0x7FFFFFFE, 0x0` (wrap-around).
